// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side operand bus into, and registered EX-side bus out of, the ID/EX stage
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 21
);
    logic [CTRL_W-1:0] id_ctrl;
    logic [XLEN-1:0]   id_instr;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;

    logic              ex_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [XLEN-1:0]   ex_instr;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [4:0]        ex_rd;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;

    modport master (
        output id_ctrl, id_instr, id_pc, id_rs1_data, id_rs2_data,
        input  ex_valid, ex_ctrl, ex_instr, ex_pc, ex_rs1_data, ex_rs2_data,
               ex_rd, ex_rs1, ex_rs2
    );

    modport slave (
        input  id_ctrl, id_instr, id_pc, id_rs1_data, id_rs2_data,
        output ex_valid, ex_ctrl, ex_instr, ex_pc, ex_rs1_data, ex_rs2_data,
               ex_rd, ex_rs1, ex_rs2
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble and flush squash
// Optional ID_EX_PERF_EN adds saturating bubble_count/flush_count outputs.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 21
) (
    input  logic            clk,
    input  logic            reset_n,
    id_ex_stage_if.slave    bus,
    input  logic            ex_flush,
    input  logic            ext_hold,
    output logic            hazard_stall
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]     bubble_count,
    output logic [31:0]     flush_count
`endif
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [XLEN-1:0]   instr_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   rs1_data_q;
    logic [XLEN-1:0]   rs2_data_q;

    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] ex_rd;
    logic       rs1_used;
    logic       rs2_used;
    logic       load_use;
    logic       bubble;

    assign id_opcode = bus.id_instr[6:0];
    assign id_rs1    = bus.id_instr[19:15];
    assign id_rs2    = bus.id_instr[24:20];
    assign ex_rd     = instr_q[11:7];

    assign rs1_used = !((id_opcode == OP_LUI) || (id_opcode == OP_JAL) || (id_opcode == OP_AUIPC));
    assign rs2_used = (id_opcode == OP_REG) || (id_opcode == OP_STORE) || (id_opcode == OP_BRANCH);

    assign load_use = valid_q && ctrl_q[16] && (ex_rd != 5'd0) &&
                      ((rs1_used && (ex_rd == id_rs1)) || (rs2_used && (ex_rd == id_rs2)));

    // A flush must let the fetch redirect through, so it masks the load-use stall.
    assign hazard_stall = reset_n && (ext_hold || (!ex_flush && load_use));
    assign bubble       = ex_flush || load_use;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            instr_q    <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else if (!ext_hold) begin
            if (bubble) begin
                valid_q    <= 1'b0;
                ctrl_q     <= '0;
                instr_q    <= '0;
                pc_q       <= '0;
                rs1_data_q <= '0;
                rs2_data_q <= '0;
            end else begin
                valid_q    <= 1'b1;
                ctrl_q     <= bus.id_ctrl;
                instr_q    <= bus.id_instr;
                pc_q       <= bus.id_pc;
                rs1_data_q <= bus.id_rs1_data;
                rs2_data_q <= bus.id_rs2_data;
            end
        end
    end

`ifdef ID_EX_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bubble_count <= '0;
            flush_count  <= '0;
        end else if (!ext_hold) begin
            if (ex_flush) begin
                if (flush_count != 32'hFFFF_FFFF) flush_count <= flush_count + 32'd1;
            end else if (load_use) begin
                if (bubble_count != 32'hFFFF_FFFF) bubble_count <= bubble_count + 32'd1;
            end
        end
    end
`endif

    assign bus.ex_valid    = valid_q;
    assign bus.ex_ctrl     = ctrl_q;
    assign bus.ex_instr    = instr_q;
    assign bus.ex_pc       = pc_q;
    assign bus.ex_rs1_data = rs1_data_q;
    assign bus.ex_rs2_data = rs2_data_q;
    assign bus.ex_rd       = instr_q[11:7];
    assign bus.ex_rs1      = instr_q[19:15];
    assign bus.ex_rs2      = instr_q[24:20];
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and randomized checks of id_ex_stage against a behavioural model
`timescale 1ns/1ps
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ex_flush = 1'b0;
    logic ext_hold = 1'b0;
    logic hazard_stall;
`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_count;
    logic [31:0] flush_count;
`endif

    id_ex_stage_if #(.XLEN(32), .CTRL_W(21)) bus ();

    id_ex_stage #(.XLEN(32), .CTRL_W(21)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .ex_flush     (ex_flush),
        .ext_hold     (ext_hold),
        .hazard_stall (hazard_stall)
`ifdef ID_EX_PERF_EN
        ,
        .bubble_count (bubble_count),
        .flush_count  (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: contents of the EX slot plus event counters.
    logic        m_valid;
    logic [20:0] m_ctrl;
    logic [31:0] m_instr, m_pc, m_a, m_b;
    longint      m_bub, m_fl;

    function automatic void model_reset();
        m_valid = 0; m_ctrl = 0; m_instr = 0; m_pc = 0; m_a = 0; m_b = 0;
        m_bub = 0; m_fl = 0;
    endfunction

    // Which source registers an instruction reads, by opcode.
    function automatic void reg_reads(input logic [31:0] ins, output bit r1, output bit r2);
        case (ins[6:0])
            7'h37, 7'h6F, 7'h17: begin r1 = 0; r2 = 0; end
            7'h33, 7'h23, 7'h63: begin r1 = 1; r2 = 1; end
            default:             begin r1 = 1; r2 = 0; end
        endcase
    endfunction

    function automatic bit model_load_use();
        bit r1, r2;
        logic [4:0] rd;
        logic [31:0] ins;
        ins = bus.id_instr;
        rd  = m_instr[11:7];
        reg_reads(ins, r1, r2);
        if (!m_valid || !m_ctrl[16] || rd == 0) return 0;
        return (r1 && rd == ins[19:15]) || (r2 && rd == ins[24:20]);
    endfunction

    function automatic bit model_stall();
        if (!reset_n) return 0;
        return ext_hold || (!ex_flush && model_load_use());
    endfunction

    function automatic void model_edge();
        bit lu;
        lu = model_load_use();
        if (ext_hold) return;
        if (ex_flush || lu) begin
            m_valid = 0; m_ctrl = 0; m_instr = 0; m_pc = 0; m_a = 0; m_b = 0;
            if (ex_flush) m_fl = (m_fl < 64'hFFFF_FFFF) ? m_fl + 1 : m_fl;
            else          m_bub = (m_bub < 64'hFFFF_FFFF) ? m_bub + 1 : m_bub;
        end else begin
            m_valid = 1; m_ctrl = bus.id_ctrl; m_instr = bus.id_instr;
            m_pc = bus.id_pc; m_a = bus.id_rs1_data; m_b = bus.id_rs2_data;
        end
    endfunction

    task automatic check_all();
        logic [31:0] ins;
        ins = m_instr;
        check("ex_valid",    bus.ex_valid,    m_valid);
        check("ex_ctrl",     bus.ex_ctrl,     m_ctrl);
        check("ex_instr",    bus.ex_instr,    m_instr);
        check("ex_pc",       bus.ex_pc,       m_pc);
        check("ex_rs1_data", bus.ex_rs1_data, m_a);
        check("ex_rs2_data", bus.ex_rs2_data, m_b);
        check("ex_rd",       bus.ex_rd,       ins[11:7]);
        check("ex_rs1",      bus.ex_rs1,      ins[19:15]);
        check("ex_rs2",      bus.ex_rs2,      ins[24:20]);
`ifdef ID_EX_PERF_EN
        check("bubble_count", bubble_count, m_bub);
        check("flush_count",  flush_count,  m_fl);
`endif
    endtask

    task automatic step(input logic [20:0] c, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b, input logic fl, input logic hd);
        @(negedge clk);
        reset_n = 1;
        bus.id_ctrl = c; bus.id_instr = ins; bus.id_pc = pc;
        bus.id_rs1_data = a; bus.id_rs2_data = b;
        ex_flush = fl; ext_hold = hd;
        #1;
        check("hazard_stall", hazard_stall, model_stall());
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Asserted between edges; outputs must clear without a clock.
    task automatic async_reset();
        #2;
        reset_n = 0;
        #1;
        model_reset();
        check("async_reset_stall", hazard_stall, 1'b0);
        check_all();
    endtask

    localparam logic [20:0] CT_ALU  = 21'h0A9000;
    localparam logic [20:0] CT_LOAD = 21'h018000;
    localparam logic [31:0] LB_X5   = 32'h00008283;
    localparam logic [31:0] LB_X0   = 32'h00008003;
    localparam logic [31:0] ADD_X6  = 32'h00528333;
    localparam logic [31:0] LUI_X5  = 32'h123452B7;
    localparam logic [31:0] ADD_X0  = 32'h00000333;
    localparam logic [31:0] ADDI_X1 = 32'h00500093;

    logic [6:0] ops [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h17};

    initial begin
        model_reset();
        bus.id_ctrl = 0; bus.id_instr = 0; bus.id_pc = 0;
        bus.id_rs1_data = 0; bus.id_rs2_data = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", hazard_stall, 1'b0);
        check_all();

        // Pass-through, then reset mid-cycle with a valid EX slot.
        step(CT_ALU, ADDI_X1, 32'h10, 32'h0, 32'h0, 0, 0);
        check("pt_ctrl", bus.ex_ctrl, 21'h0A9000);
        check("pt_rd", bus.ex_rd, 5'd1);
        check("pt_pc", bus.ex_pc, 32'h10);
        check("pt_valid", bus.ex_valid, 1'b1);
        async_reset();
        check("rst_valid", bus.ex_valid, 1'b0);

        // Load-use: one bubble then the dependent add issues.
        step(CT_LOAD, LB_X5, 32'h20, 32'h1, 32'h2, 0, 0);
        step(CT_ALU, ADD_X6, 32'h24, 32'h3, 32'h4, 0, 0);
        check("lu_valid", bus.ex_valid, 1'b0);
        check("lu_ctrl", bus.ex_ctrl, 21'h0);
        step(CT_ALU, ADD_X6, 32'h24, 32'h3, 32'h4, 0, 0);
        check("lu_issue", bus.ex_instr, ADD_X6);

        // No false hazard: LUI has no source, and x0 loads never stall.
        step(CT_LOAD, LB_X5, 32'h30, 0, 0, 0, 0);
        step(CT_ALU, LUI_X5, 32'h34, 0, 0, 0, 0);
        check("lui_issue", bus.ex_instr, LUI_X5);
        step(CT_LOAD, LB_X0, 32'h38, 0, 0, 0, 0);
        step(CT_ALU, ADD_X0, 32'h3C, 0, 0, 0, 0);
        check("x0_issue", bus.ex_instr, ADD_X0);

        // Flush beats stall, counted from a fresh reset.
        step(CT_LOAD, LB_X5, 32'h40, 0, 0, 0, 0);
        async_reset();
        step(CT_LOAD, LB_X5, 32'h40, 0, 0, 0, 0);
        @(negedge clk);
        bus.id_ctrl = CT_ALU; bus.id_instr = ADD_X6; ex_flush = 1;
        #1;
        check("flush_stall", hazard_stall, 1'b0);
        @(posedge clk); model_edge(); #1; check_all();
        check("flush_valid", bus.ex_valid, 1'b0);
`ifdef ID_EX_PERF_EN
        check("flush_cnt1", flush_count, 32'd1);
        check("bubble_cnt0", bubble_count, 32'd0);
`endif

        // Hold for 3 cycles with changing inputs and flush asserted.
        step(CT_ALU, ADDI_X1, 32'h50, 32'h5, 32'h6, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(21'($urandom), $urandom, $urandom, $urandom, $urandom, 1, 1);
            check("hold_instr", bus.ex_instr, ADDI_X1);
            check("hold_pc", bus.ex_pc, 32'h50);
        end
        step(CT_ALU, ADD_X6, 32'h54, 0, 0, 1, 0);
        check("hold_rel_flush", bus.ex_valid, 1'b0);
        step(CT_ALU, ADD_X6, 32'h58, 0, 0, 0, 0);
        check("hold_rel_cap", bus.ex_pc, 32'h58);

        // Randomized traffic with small register indices to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            logic [20:0] c;
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 7)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            c = 21'($urandom);
            if ($urandom_range(0, 3) == 0) c = 0;
            step(c, ins, $urandom, $urandom, $urandom,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
            if ($urandom_range(0, 60) == 0) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
